split: RTL and testbench
========================

Name: split

Overview:
- Routes one master's native request bus to one of N_SLAVES slave buses. It is the demultiplexing counterpart of the N-to-1 merge in the interconnect.
- Slave selection comes from the top address bits.
- The response is routed back from the slave that owns the outstanding transaction.
- Unmapped addresses get an error response generated locally. Slaves that never assert ready are aborted by an optional timeout, so the master never hangs.

Parameters:
- N_SLAVES, 2, number of slave ports (>=1).
- DATA_W, 32, data width.
- ADDR_W, 32, address width.
- TIMEOUT_CYC, 255, maximum BUSY cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- m_req  in  `REQ_W  master request {valid, address, wdata, wstrb}.
- m_resp  out  `RESP_W  master response {rdata, ready}.
- s_req  out  N_SLAVES*`REQ_W  slave requests; slave k occupies `req(k).
- s_resp  in  N_SLAVES*`RESP_W  slave responses; slave k occupies `resp(k).
- err  out  1  one-cycle pulse coincident with every locally generated error response.

Behaviour:
- Reset and clocking: one clock (clk). Reset (rst) is synchronous and active-high.
- Constants: Nb = $clog2(N_SLAVES), forced to 1 when N_SLAVES==1.
- Decode: idx = m_req address bits [ADDR_W-1 -: Nb]. The address is mapped iff idx < N_SLAVES. When N_SLAVES==1, idx is forced to 0 and every address is mapped.
- Protocol rule: the master holds valid and all request fields stable until it sees ready=1. The transfer completes in the cycle where ready=1.
- FSM states: IDLE, BUSY, ERR. Registers: state, sel_reg[Nb-1:0], tcnt (width $clog2(TIMEOUT_CYC+1), minimum 1), err.
- IDLE, valid=0:
  - all s_req are zero and m_resp is zero.
- IDLE, valid=1 with a mapped address:
  - m_req is driven combinationally onto s_req[idx]; all other slave requests are zero.
  - m_resp = s_resp[idx].
  - sel_reg <= idx.
  - If s_resp[idx].ready=1 in the same cycle, the transfer completes with zero added latency and the FSM stays in IDLE.
  - Otherwise the FSM moves to BUSY with tcnt <= 1.
- IDLE, valid=1 with an unmapped address:
  - all s_req are zero.
  - Next state is ERR.
- BUSY:
  - m_req is forwarded to s_req[sel_reg] and m_resp = s_resp[sel_reg]. The decode is ignored.
  - On ready=1 the FSM returns to IDLE.
  - Otherwise, if TIMEOUT_CYC!=0 and tcnt==TIMEOUT_CYC, the FSM moves to ERR. In that case the slave request is driven zero from the next cycle (abort).
  - Otherwise tcnt <= tcnt+1.
- ERR (exactly one cycle):
  - all s_req are zero.
  - m_resp.ready=1 and m_resp.rdata=`SPLIT_ERR_DATA (32'hDEADBEEF truncated or zero-extended to DATA_W).
  - err=1 (registered, asserted for exactly this cycle).
  - Next state is IDLE. A master request presented in the following cycle is handled as a new transaction.
- Latency:
  - Request path is combinational (0 cycles).
  - Error response 1 cycle after an unmapped request.
  - Timeout error TIMEOUT_CYC+1 cycles after request presentation.
- Simultaneous events: in BUSY, a ready that arrives in the same cycle the timeout hits wins. The transfer completes normally with no error.
- Stray slave ready: ready from a non-selected slave is ignored and never reaches m_resp.
- Reset mid-operation:
  - next edge forces IDLE, sel_reg=0, tcnt=0, err=0.
  - While rst=1, all s_req and m_resp are driven zero regardless of m_req.
  - Any outstanding slave transaction is abandoned.
- No combinational loop between ready and valid inside the block.

Decomposition:
- interconnect.vh already provides `REQ_W, `RESP_W, `req(k), `resp(k), `valid(k), `address(k,W), `ready(k) and `rdata(k); reuse them.
- Add `SPLIT_ERR_DATA to interconnect.vh.
- The FSM state encodings are localparams inside split.
- One natural sub-module: split_timeout (counter with enable/clear, TIMEOUT_CYC parameter, expired flag). It is omitted when TIMEOUT_CYC==0.

Test Plan:
- Zero-latency read: N_SLAVES=2, addr=0x8000_0010, slave1 ready in the same cycle with rdata=0x1234 -> m_resp {0x1234, ready=1} that cycle; s_req[0] stays zero; FSM stays IDLE.
- Wait states: addr=0x0000_0004, slave0 ready after 3 cycles -> master sees ready only on cycle 3; sel_reg=0 throughout; stray slave1 ready pulses are not visible on m_resp.
- Unmapped: N_SLAVES=3, addr=0xC000_0000 -> no s_req valid; next cycle m_resp.ready=1, rdata=0xDEADBEEF, err=1 for exactly 1 cycle.
- Timeout: TIMEOUT_CYC=4, slave0 never ready -> s_req[0] valid for 5 cycles, then ERR cycle with ready=1, rdata=0xDEADBEEF, err=1, and s_req[0] zero. Second run: ready arrives in the tcnt==4 cycle -> normal completion, err=0.
- Reset mid-BUSY: assert rst during a BUSY cycle -> that cycle s_req=0 and m_resp=0; after release a new request to slave1 is routed correctly with tcnt starting from 1.
- Back-to-back: a request to slave0 completes, then next cycle a request to slave1 -> routed to slave1 with no bubble; TIMEOUT_CYC=0 with an unresponsive slave stays BUSY indefinitely (checked for 1000 cycles).

Source files
------------

// File: rtl/split_pkg.sv
// Interconnect bus field macros and split helpers. The macros expect DATA_W and ADDR_W in scope.
`ifndef INTERCONNECT_VH
`define INTERCONNECT_VH
`define REQ_W (1 + ADDR_W + DATA_W + DATA_W/8)
`define RESP_W (DATA_W + 1)
`define REQ_OFF(k) ((k) * `REQ_W)
`define RESP_OFF(k) ((k) * `RESP_W)
`define VALID_BIT(k) ( `REQ_OFF(k) + `REQ_W - 1)
`define ADDR_MSB(k) ( `REQ_OFF(k) + `REQ_W - 2)
`define READY_BIT(k) ( `RESP_OFF(k))
`define RDATA_LSB(k) ( `RESP_OFF(k) + 1)
`endif

`ifndef SPLIT_ERR_DATA
`define SPLIT_ERR_DATA (DATA_W'(32'hDEADBEEF))
`endif

package split_pkg;

  // Width of the slave select; a single slave still needs one bit.
  function automatic int unsigned sel_width(input int unsigned n_slaves);
    return (n_slaves > 1) ? $clog2(n_slaves) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned timeout_cyc);
    return (timeout_cyc > 0) ? $clog2(timeout_cyc + 1) : 1;
  endfunction

endpackage

// File: rtl/split_timeout.sv
// BUSY-cycle counter: load starts a count at 1, inc advances it, expired_c flags the limit.
module split_timeout
  import split_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = cnt_width(TIMEOUT_CYC)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  output logic expired_c
);

  logic [CNT_W-1:0] tcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
    end else if (load) begin
      tcnt <= CNT_W'(1);
    end else if (inc) begin
      tcnt <= tcnt + CNT_W'(1);
    end
  end

  assign expired_c = (tcnt == CNT_W'(TIMEOUT_CYC));

endmodule

// File: rtl/split.sv
// 1-to-N request demultiplexer: address-decoded slave select, response return path,
// local error response for unmapped addresses and optional BUSY timeout.
module split
  import split_pkg::*;
#(
  parameter int unsigned N_SLAVES    = 2,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [`REQ_W-1:0]            m_req,
  output logic [`RESP_W-1:0]           m_resp,
  output logic [N_SLAVES*`REQ_W-1:0]   s_req,
  input  logic [N_SLAVES*`RESP_W-1:0]  s_resp,
  output logic                         err
);

  localparam int unsigned NB = sel_width(N_SLAVES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [NB-1:0]      sel_reg, sel_nxt;
  logic [NB-1:0]      idx_c, route_idx_c;
  logic               mapped_c, route_c;
  logic               err_nxt, tload, tinc, expired_c;
  logic [`RESP_W-1:0] sel_resp_c;

  // Address decode from the top address bits
  generate
    if (N_SLAVES == 1) begin : g_single
      assign idx_c    = '0;
      assign mapped_c = 1'b1;
    end else if (N_SLAVES == (32'd1 << NB)) begin : g_pow2
      assign idx_c    = m_req[`ADDR_MSB(0) -: NB];
      assign mapped_c = 1'b1;
    end else begin : g_sparse
      assign idx_c    = m_req[`ADDR_MSB(0) -: NB];
      assign mapped_c = (idx_c < NB'(N_SLAVES));
    end
  endgenerate

  // IDLE routes by the live decode; BUSY sticks to the owning slave
  assign route_idx_c = (state == ST_IDLE) ? idx_c : sel_reg;

  always_comb begin : sel_resp_mux
    sel_resp_c = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (route_idx_c == NB'(k)) sel_resp_c = s_resp[`RESP_OFF(k) +: `RESP_W];
    end
  end

  always_comb begin : fsm_comb
    state_nxt = state;
    sel_nxt   = sel_reg;
    err_nxt   = 1'b0;
    route_c   = 1'b0;
    tload     = 1'b0;
    tinc      = 1'b0;
    m_resp    = '0;
    if (!rst) begin
      unique case (state)
        ST_IDLE: begin
          if (m_req[`VALID_BIT(0)]) begin
            if (mapped_c) begin
              route_c = 1'b1;
              sel_nxt = idx_c;
              if (!sel_resp_c[`READY_BIT(0)]) begin
                state_nxt = ST_BUSY;
                tload     = 1'b1;
              end
            end else begin
              state_nxt = ST_ERR;
              err_nxt   = 1'b1;
            end
          end
        end
        ST_BUSY: begin
          route_c = 1'b1;
          // A ready arriving on the expiry cycle still completes normally
          if (sel_resp_c[`READY_BIT(0)]) begin
            state_nxt = ST_IDLE;
          end else if (expired_c) begin
            state_nxt = ST_ERR;
            err_nxt   = 1'b1;
          end else begin
            tinc = 1'b1;
          end
        end
        ST_ERR: begin
          m_resp    = {`SPLIT_ERR_DATA, 1'b1};
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
      if (route_c) m_resp = sel_resp_c;
    end
  end

  always_comb begin : req_route
    s_req = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (route_c && (route_idx_c == NB'(k))) s_req[`REQ_OFF(k) +: `REQ_W] = m_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sel_reg <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      sel_reg <= sel_nxt;
      err     <= err_nxt;
    end
  end

  generate
    if (TIMEOUT_CYC != 0) begin : g_timeout
      split_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
      ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .load      (tload),
        .inc       (tinc),
        .expired_c (expired_c)
      );
    end else begin : g_no_timeout
      logic unused_tctl;
      assign unused_tctl = tload ^ tinc;
      assign expired_c   = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_split.sv
// Directed bench for split: three instances cover 2 slaves with a short timeout,
// 3 slaves with a sparse map, and 2 slaves with the timeout disabled.
module tb_split;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned RQ = 1 + AW + DW + DW/8;
  localparam int unsigned RS = DW + 1;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [RQ-1:0]   a_m_req, b_m_req, c_m_req;
  logic [RS-1:0]   a_m_resp, b_m_resp, c_m_resp;
  logic [2*RQ-1:0] a_s_req, c_s_req;
  logic [3*RQ-1:0] b_s_req;
  logic [2*RS-1:0] a_s_resp, c_s_resp;
  logic [3*RS-1:0] b_s_resp;
  logic            a_err, b_err, c_err;

  int checks = 0;
  int errors = 0;

  split #(.N_SLAVES(2), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(4)) u_a (
    .clk(clk), .rst(rst), .m_req(a_m_req), .m_resp(a_m_resp),
    .s_req(a_s_req), .s_resp(a_s_resp), .err(a_err));

  split #(.N_SLAVES(3), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(255)) u_b (
    .clk(clk), .rst(rst), .m_req(b_m_req), .m_resp(b_m_resp),
    .s_req(b_s_req), .s_resp(b_s_resp), .err(b_err));

  split #(.N_SLAVES(2), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(0)) u_c (
    .clk(clk), .rst(rst), .m_req(c_m_req), .m_resp(c_m_resp),
    .s_req(c_s_req), .s_resp(c_s_resp), .err(c_err));

  function automatic logic [RQ-1:0] mk_req(input logic v, input logic [31:0] a,
                                           input logic [31:0] d, input logic [3:0] s);
    return {v, a, d, s};
  endfunction

  function automatic logic [RS-1:0] mk_resp(input logic [31:0] d, input logic r);
    return {d, r};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_m_req  = mk_req(1'b1, 32'h8000_0000, 32'h1111_1111, 4'hF);
    a_s_resp = {mk_resp(32'h2222, 1'b1), mk_resp(32'h3333, 1'b1)};
    @(negedge clk);
    #1;
    checks++; if (a_s_req !== '0) begin errors++; $display("FAIL rst_sreq: got %h expected 0", a_s_req); end
    checks++; if (a_m_resp !== '0) begin errors++; $display("FAIL rst_mresp: got %h expected 0", a_m_resp); end
    checks++; if ({a_err, b_err, c_err} !== 3'b000) begin errors++; $display("FAIL rst_err: got %b expected 000", {a_err, b_err, c_err}); end
    rst = 1'b0;
    a_m_req  = '0;
    a_s_resp = '0;
    step();
  endtask

  task automatic test_zero_latency();
    logic [RQ-1:0] rq;
    rq = mk_req(1'b1, 32'h8000_0010, 32'hCAFE_0001, 4'hF);
    a_m_req  = rq;
    a_s_resp = {mk_resp(32'h1234, 1'b1), mk_resp(32'h9999, 1'b0)};
    #1;
    checks++; if (a_m_resp !== mk_resp(32'h1234, 1'b1)) begin errors++; $display("FAIL zl_resp: got %h expected %h", a_m_resp, mk_resp(32'h1234, 1'b1)); end
    checks++; if (a_s_req !== {rq, {RQ{1'b0}}}) begin errors++; $display("FAIL zl_sreq: got %h expected %h", a_s_req, {rq, {RQ{1'b0}}}); end
    step();
    a_m_req = '0;
    #1;
    checks++; if (a_m_resp !== '0) begin errors++; $display("FAIL zl_idle_resp: got %h expected 0", a_m_resp); end
    checks++; if (a_s_req !== '0) begin errors++; $display("FAIL zl_idle_sreq: got %h expected 0", a_s_req); end
    a_s_resp = '0;
    step();
  endtask

  task automatic test_wait_states();
    logic [RQ-1:0] rq;
    logic [RS-1:0] exp_r;
    rq = mk_req(1'b1, 32'h0000_0004, 32'h0, 4'h0);
    a_m_req = rq;
    for (int c = 0; c < 4; c++) begin
      exp_r = mk_resp((c == 3) ? 32'h7777 : 32'h5555, c == 3);
      a_s_resp = {mk_resp(32'hBAD0_0000 + 32'(c), (c % 2) == 1), exp_r};
      #1;
      checks++; if (a_m_resp !== exp_r) begin errors++; $display("FAIL ws_resp c%0d: got %h expected %h", c, a_m_resp, exp_r); end
      checks++; if (a_s_req !== {{RQ{1'b0}}, rq}) begin errors++; $display("FAIL ws_sreq c%0d: got %h expected %h", c, a_s_req, {{RQ{1'b0}}, rq}); end
      step();
    end
    a_m_req  = '0;
    a_s_resp = {mk_resp(32'hBAD0, 1'b1), mk_resp(32'h0, 1'b0)};
    #1;
    checks++; if (a_m_resp !== '0) begin errors++; $display("FAIL ws_idle: got %h expected 0", a_m_resp); end
    a_s_resp = '0;
    step();
  endtask

  task automatic test_timeout();
    logic [RQ-1:0] rq;
    rq = mk_req(1'b1, 32'h0000_0100, 32'hAAAA_5555, 4'h3);
    a_m_req  = rq;
    a_s_resp = {mk_resp(32'h0, 1'b1), mk_resp(32'h1, 1'b0)};
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (a_s_req !== {{RQ{1'b0}}, rq}) begin errors++; $display("FAIL to_sreq c%0d: got %h expected %h", c, a_s_req, {{RQ{1'b0}}, rq}); end
      checks++; if (a_m_resp !== mk_resp(32'h1, 1'b0) || a_err !== 1'b0) begin errors++; $display("FAIL to_wait c%0d: resp %h err %b expected %h err 0", c, a_m_resp, a_err, mk_resp(32'h1, 1'b0)); end
      step();
    end
    #1;
    checks++; if (a_m_resp !== mk_resp(ERRD, 1'b1)) begin errors++; $display("FAIL to_errresp: got %h expected %h", a_m_resp, mk_resp(ERRD, 1'b1)); end
    checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", a_err); end
    checks++; if (a_s_req !== '0) begin errors++; $display("FAIL to_abort: got %h expected 0", a_s_req); end
    step();
    a_m_req  = '0;
    a_s_resp = '0;
    #1;
    checks++; if (a_err !== 1'b0 || a_m_resp !== '0) begin errors++; $display("FAIL to_after: err %b resp %h expected 0 0", a_err, a_m_resp); end
    step();
    // ready on the expiry cycle completes normally
    rq = mk_req(1'b1, 32'h0000_0040, 32'h0, 4'h0);
    a_m_req = rq;
    for (int c = 0; c < 5; c++) begin
      a_s_resp = {mk_resp(32'h0, 1'b0), mk_resp(32'h4444, c == 4)};
      #1;
      checks++; if (a_m_resp !== mk_resp(32'h4444, c == 4) || a_err !== 1'b0) begin errors++; $display("FAIL race c%0d: resp %h err %b expected %h err 0", c, a_m_resp, a_err, mk_resp(32'h4444, c == 4)); end
      step();
    end
    a_m_req  = '0;
    a_s_resp = '0;
    #1;
    checks++; if (a_err !== 1'b0 || a_m_resp !== '0) begin errors++; $display("FAIL race_after: err %b resp %h expected 0 0", a_err, a_m_resp); end
    step();
  endtask

  task automatic test_reset_mid_busy();
    logic [RQ-1:0] rq;
    rq = mk_req(1'b1, 32'h0000_0008, 32'h0, 4'h0);
    a_m_req  = rq;
    a_s_resp = '0;
    step();
    step();
    rst = 1'b1;
    a_s_resp = {mk_resp(32'h1, 1'b1), mk_resp(32'h2, 1'b1)};
    #1;
    checks++; if (a_s_req !== '0 || a_m_resp !== '0) begin errors++; $display("FAIL rmb_zero: sreq %h resp %h expected 0 0", a_s_req, a_m_resp); end
    step();
    rst = 1'b0;
    a_m_req  = '0;
    a_s_resp = '0;
    #1;
    checks++; if (a_m_resp !== '0 || a_err !== 1'b0) begin errors++; $display("FAIL rmb_idle: resp %h err %b expected 0 0", a_m_resp, a_err); end
    step();
    rq = mk_req(1'b1, 32'h8000_0004, 32'h0BAD_F00D, 4'hC);
    a_m_req = rq;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (a_s_req !== {rq, {RQ{1'b0}}} || a_err !== 1'b0) begin errors++; $display("FAIL rmb_route c%0d: sreq %h err %b expected %h err 0", c, a_s_req, a_err, {rq, {RQ{1'b0}}}); end
      step();
    end
    #1;
    checks++; if (a_err !== 1'b1 || a_m_resp !== mk_resp(ERRD, 1'b1)) begin errors++; $display("FAIL rmb_tcnt: err %b resp %h expected 1 %h", a_err, a_m_resp, mk_resp(ERRD, 1'b1)); end
    step();
    a_m_req = '0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [RQ-1:0] r0, r1;
    r0 = mk_req(1'b1, 32'h0000_0010, 32'h0000_0101, 4'hF);
    r1 = mk_req(1'b1, 32'h8000_0020, 32'h0000_0202, 4'hF);
    a_m_req  = r0;
    a_s_resp = {mk_resp(32'hB1, 1'b0), mk_resp(32'hA0, 1'b1)};
    #1;
    checks++; if (a_m_resp !== mk_resp(32'hA0, 1'b1) || a_s_req !== {{RQ{1'b0}}, r0}) begin errors++; $display("FAIL b2b_first: resp %h sreq %h", a_m_resp, a_s_req); end
    step();
    a_m_req  = r1;
    a_s_resp = {mk_resp(32'hB1, 1'b1), mk_resp(32'hA0, 1'b0)};
    #1;
    checks++; if (a_m_resp !== mk_resp(32'hB1, 1'b1)) begin errors++; $display("FAIL b2b_resp: got %h expected %h", a_m_resp, mk_resp(32'hB1, 1'b1)); end
    checks++; if (a_s_req !== {r1, {RQ{1'b0}}}) begin errors++; $display("FAIL b2b_sreq: got %h expected %h", a_s_req, {r1, {RQ{1'b0}}}); end
    step();
    a_m_req  = '0;
    a_s_resp = '0;
    #1;
    checks++; if (a_m_resp !== '0) begin errors++; $display("FAIL b2b_idle: got %h expected 0", a_m_resp); end
    step();
  endtask

  task automatic test_unmapped();
    logic [RQ-1:0] rq;
    rq = mk_req(1'b1, 32'hC000_0000, 32'h1, 4'h1);
    b_m_req  = rq;
    b_s_resp = {mk_resp(32'h3, 1'b1), mk_resp(32'h2, 1'b1), mk_resp(32'h1, 1'b1)};
    #1;
    checks++; if (b_s_req !== '0) begin errors++; $display("FAIL um_sreq: got %h expected 0", b_s_req); end
    checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL um_err0: got %b expected 0", b_err); end
    step();
    #1;
    checks++; if (b_m_resp !== mk_resp(ERRD, 1'b1)) begin errors++; $display("FAIL um_resp: got %h expected %h", b_m_resp, mk_resp(ERRD, 1'b1)); end
    checks++; if (b_err !== 1'b1) begin errors++; $display("FAIL um_err1: got %b expected 1", b_err); end
    checks++; if (b_s_req !== '0) begin errors++; $display("FAIL um_sreq_err: got %h expected 0", b_s_req); end
    step();
    rq = mk_req(1'b1, 32'h8000_0000, 32'h2, 4'h2);
    b_m_req = rq;
    #1;
    checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL um_err_pulse: got %b expected 0", b_err); end
    checks++; if (b_m_resp !== mk_resp(32'h3, 1'b1)) begin errors++; $display("FAIL um_next_resp: got %h expected %h", b_m_resp, mk_resp(32'h3, 1'b1)); end
    checks++; if (b_s_req !== {rq, {(2*RQ){1'b0}}}) begin errors++; $display("FAIL um_next_sreq: got %h expected %h", b_s_req, {rq, {(2*RQ){1'b0}}}); end
    step();
    b_m_req  = '0;
    b_s_resp = '0;
    step();
  endtask

  task automatic test_no_timeout();
    logic [RQ-1:0] rq;
    rq = mk_req(1'b1, 32'h0000_0000, 32'h0, 4'h0);
    c_m_req  = rq;
    c_s_resp = {mk_resp(32'h5, 1'b1), mk_resp(32'h6, 1'b0)};
    for (int c = 0; c < 1000; c++) begin
      #1;
      checks++;
      if (c_s_req !== {{RQ{1'b0}}, rq} || c_err !== 1'b0 || c_m_resp !== mk_resp(32'h6, 1'b0)) begin
        errors++;
        $display("FAIL nt_busy c%0d: sreq %h err %b resp %h", c, c_s_req, c_err, c_m_resp);
      end
      step();
    end
    c_s_resp = {mk_resp(32'h5, 1'b0), mk_resp(32'h77, 1'b1)};
    #1;
    checks++; if (c_m_resp !== mk_resp(32'h77, 1'b1)) begin errors++; $display("FAIL nt_done: got %h expected %h", c_m_resp, mk_resp(32'h77, 1'b1)); end
    step();
    c_m_req  = '0;
    c_s_resp = '0;
    #1;
    checks++; if (c_m_resp !== '0) begin errors++; $display("FAIL nt_idle: got %h expected 0", c_m_resp); end
    step();
  endtask

  initial begin
    rst = 1'b1;
    a_m_req = '0; b_m_req = '0; c_m_req = '0;
    a_s_resp = '0; b_s_resp = '0; c_s_resp = '0;
    test_reset();
    test_zero_latency();
    test_wait_states();
    test_timeout();
    test_reset_mid_busy();
    test_back_to_back();
    test_unmapped();
    test_no_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
